// File: rtl/tape_player.sv
// Cassette playback engine: leader, sync bit, then buffered bytes as FSK ear pulses.
// Optional motor gating is enabled by defining TAPE_MOTOR_GATE_EN.
module tape_player #(
    parameter int ZERO_HALF   = 1000,
    parameter int ONE_HALF    = 500,
    parameter int LEADER_BITS = 768
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ce,
    input  logic        start,
    input  logic [15:0] len,
    input  logic        motor,
    output logic [15:0] rd_addr,
    input  logic [7:0]  rd_data,
    output logic        rd_req,
    output logic        ear,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {IDLE, LEADER, SYNC, DATA, END} state_t;

    localparam logic [15:0] ZERO_LAST = 16'(ZERO_HALF - 1);
    localparam logic [15:0] ONE_LAST  = 16'(ONE_HALF - 1);
    localparam logic [15:0] LEAD_LAST = 16'(LEADER_BITS - 1);

    state_t      state_q, state_d;
    logic [15:0] cnt_q;
    logic        hi_q;
    logic [15:0] bit_cnt_q;
    logic [15:0] byte_idx_q;
    logic [15:0] last_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic [7:0]  next_q;
    logic        rd_pend_q;

    logic        active;
    logic        motor_ok;
    logic        run;
    logic        bit_val;
    logic [15:0] half_last;
    logic        half_end;
    logic        bit_end;
    logic        byte_last;
    logic        data_last;

`ifdef TAPE_MOTOR_GATE_EN
    assign motor_ok = motor;
`else
    logic unused_motor;
    assign unused_motor = motor;
    assign motor_ok     = 1'b1;
`endif

    always_comb begin
        active    = (state_q == LEADER) || (state_q == SYNC) || (state_q == DATA);
        run       = active && ce && motor_ok;
        bit_val   = (state_q == SYNC) || ((state_q == DATA) && shift_q[7]);
        half_last = bit_val ? ONE_LAST : ZERO_LAST;
        half_end  = run && (cnt_q == half_last);
        bit_end   = half_end && !hi_q;
        byte_last = (bit_idx_q == 3'd0);
        data_last = byte_last && (byte_idx_q == last_q);
        state_d   = state_q;
        unique case (state_q)
            IDLE:    if (start && (len != 16'd0)) state_d = LEADER;
            LEADER:  if (bit_end && (bit_cnt_q == LEAD_LAST)) state_d = SYNC;
            SYNC:    if (bit_end) state_d = DATA;
            DATA:    if (bit_end && data_last) state_d = END;
            END:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ear  = active && hi_q;
    assign busy = active;
    assign done = (state_q == END);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hi_q       <= 1'b0;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
            last_q     <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            next_q     <= '0;
            rd_pend_q  <= 1'b0;
            rd_req     <= 1'b0;
            rd_addr    <= '0;
        end else begin
            state_q   <= state_d;
            rd_req    <= 1'b0;
            rd_pend_q <= rd_req;
            if (rd_pend_q) next_q <= rd_data;
            if ((state_q == IDLE) && (state_d == LEADER)) begin
                last_q     <= len - 16'd1;
                rd_addr    <= '0;
                rd_req     <= 1'b1;
                cnt_q      <= '0;
                hi_q       <= 1'b1;
                bit_cnt_q  <= '0;
                byte_idx_q <= '0;
                bit_idx_q  <= '0;
            end else if (run) begin
                if (!half_end) begin
                    cnt_q <= cnt_q + 16'd1;
                end else begin
                    cnt_q <= '0;
                    hi_q  <= !hi_q;
                    if (bit_end) begin
                        unique case (state_q)
                            LEADER: bit_cnt_q <= bit_cnt_q + 16'd1;
                            SYNC: begin
                                shift_q    <= next_q;
                                bit_idx_q  <= 3'd7;
                                byte_idx_q <= '0;
                                if (last_q != 16'd0) begin
                                    rd_addr <= 16'd1;
                                    rd_req  <= 1'b1;
                                end
                            end
                            DATA: begin
                                if (!byte_last) begin
                                    shift_q   <= shift_q << 1;
                                    bit_idx_q <= bit_idx_q - 3'd1;
                                end else if (!data_last) begin
                                    // next byte starts: prefetch the one after it
                                    byte_idx_q <= byte_idx_q + 16'd1;
                                    shift_q    <= next_q;
                                    bit_idx_q  <= 3'd7;
                                    if (byte_idx_q + 16'd1 != last_q) begin
                                        rd_addr <= rd_addr + 16'd1;
                                        rd_req  <= 1'b1;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tape_player.sv
// Bench for tape_player: tick-level waveform model, scenario table, random runs.
// Define TAPE_MOTOR_GATE_EN to build against the motor-gated variant.
module tb_tape_player;

    localparam int ZH = 4;
    localparam int OH = 2;
    localparam int LB = 2;
`ifdef TAPE_MOTOR_GATE_EN
    localparam bit GATE = 1'b1;
`else
    localparam bit GATE = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ce = 1'b1;
    logic        start = 1'b0;
    logic [15:0] len = '0;
    logic        motor = 1'b1;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data = '0;
    logic        rd_req;
    logic        ear;
    logic        busy;
    logic        done;

    logic [7:0] mem [0:7];
    int checks = 0;
    int errors = 0;

    tape_player #(.ZERO_HALF(ZH), .ONE_HALF(OH), .LEADER_BITS(LB)) dut (
        .clock(clock), .reset(reset), .ce(ce), .start(start),
        .len(len), .motor(motor), .rd_addr(rd_addr), .rd_data(rd_data),
        .rd_req(rd_req), .ear(ear), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) if (rd_req) rd_data <= mem[rd_addr[2:0]];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {12'h0, busy, done, ear, rd_req, rd_req ? rd_addr : 16'h0};
    endfunction

    // Entered just after a posedge; cycle 0 carries the start request.
    task automatic play(input int n, input int ce_pct, input int mot_pct,
                        input int off_at, input int off_len,
                        input int restart_at, output int done_cyc);
        int wave[$];
        int starts[$];
        int total, consumed, prev, limit, h, ea;
        bit er, tk;
        logic [31:0] exp;
        for (int i = 0; i < LB; i++) begin
            repeat (ZH) wave.push_back(1);
            repeat (ZH) wave.push_back(0);
        end
        repeat (OH) wave.push_back(1);
        repeat (OH) wave.push_back(0);
        for (int b = 0; b < n; b++) begin
            starts.push_back(wave.size());
            for (int k = 7; k >= 0; k--) begin
                h = mem[b][k] ? OH : ZH;
                repeat (h) wave.push_back(1);
                repeat (h) wave.push_back(0);
            end
        end
        total = wave.size();
        limit = total * 10 + 200;
        done_cyc = -1;
        consumed = 0;
        prev = 0;
        for (int c = 0; c <= limit; c++) begin
            start = (c == 0) || (c == restart_at);
            len   = n[15:0];
            ce    = (c == 0) ? 1'b1 : ($urandom_range(99) < ce_pct);
            motor = (c >= off_at && c < off_at + off_len) ? 1'b0
                  : ($urandom_range(99) < mot_pct);
            @(negedge clock);
            if (c >= 1) begin
                er = 1'b0;
                ea = 0;
                if (n == 0) begin
                    exp = 32'h0;
                end else if (consumed < total) begin
                    if (c == 1) begin
                        er = 1'b1;
                    end else if (consumed != prev) begin
                        foreach (starts[b])
                            if (starts[b] == consumed && b + 1 < n) begin
                                er = 1'b1;
                                ea = b + 1;
                            end
                    end
                    exp = {12'h0, 1'b1, 1'b0, wave[consumed] == 1, er,
                           er ? ea[15:0] : 16'h0};
                end else begin
                    exp = {12'h0, 4'b0100, 16'h0};
                    done_cyc = c;
                end
                check($sformatf("cycle%0d", c), outs(), exp);
                tk = (consumed < total) && ce && (motor || !GATE);
                prev = consumed;
                if (n != 0 && tk) consumed++;
                if (done_cyc >= 0 || (n == 0 && c >= 30)) break;
            end
            @(posedge clock);
            #1;
        end
        start = 1'b0;
        @(posedge clock);
        #1;
        check("after_end", {30'h0, busy, done}, 32'h0);
        if (n != 0 && done_cyc < 0) check("timeout", 32'h1, 32'h0);
    endtask

    typedef struct {
        int n;
        logic [7:0] b0, b1, b2;
        int ce_pct, off_at, off_len, restart_at, exp_done;
    } vec_t;

    vec_t vt [7];
    int dc;

    initial begin
        vt[0] = '{1, 8'h80, 8'h00, 8'h00, 100, 0, 0, -1, 81};
        vt[1] = '{3, 8'h00, 8'hFF, 8'h55, 100, 0, 0, -1, 165};
        vt[2] = '{0, 8'h80, 8'h00, 8'h00, 100, 0, 0, -1, -1};
        vt[3] = '{1, 8'hFF, 8'h00, 8'h00, 100, 0, 0, -1, 53};
        vt[4] = '{1, 8'h80, 8'h00, 8'h00, 100, 17, 10, -1, GATE ? 91 : 81};
        vt[5] = '{2, 8'h00, 8'h01, 8'h00, 100, 0, 0, 30, 145};
        vt[6] = '{1, 8'h80, 8'h00, 8'h00, 100, 0, 0, 5, 81};
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;

        repeat (3) @(posedge clock);
        #1;
        check("reset_state", {busy, done, ear, rd_req, rd_addr}, 32'h0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < 7; i++) begin
            mem[0] = vt[i].b0;
            mem[1] = vt[i].b1;
            mem[2] = vt[i].b2;
            play(vt[i].n, vt[i].ce_pct, 100, vt[i].off_at, vt[i].off_len,
                 vt[i].restart_at, dc);
            check($sformatf("done_cycle_vec%0d", i), dc, vt[i].exp_done);
        end

        // Abort mid-playback, then replay from the leader.
        mem[0] = 8'h80;
        len = 16'd1;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (29) @(posedge clock);
        #1;
        check("busy_before_rst", {31'h0, busy}, 32'h1);
        reset = 1'b0;
        start = 1'b1;
        #1;
        check("async_rst", {busy, done, ear, rd_req, rd_addr}, 32'h0);
        repeat (3) begin
            @(negedge clock);
            check("rst_vs_start", {30'h0, busy, done}, 32'h0);
        end
        @(posedge clock);
        #1;
        start = 1'b0;
        reset = 1'b1;
        repeat (20) begin
            @(negedge clock);
            check("no_done_after_abort", {30'h0, busy, done}, 32'h0);
        end
        @(posedge clock);
        #1;
        play(1, 100, 100, 0, 0, -1, dc);
        check("replay_done", dc, 81);

        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 8; i++) mem[i] = 8'($urandom);
            play($urandom_range(1, 4), $urandom_range(40, 100),
                 $urandom_range(60, 100), 0, 0, -1, dc);
            check($sformatf("rand_done%0d", t), {31'h0, dc > 0}, 32'h1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
